// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC opcode map, sequencer state encoding and mux-select encodings.
// Pure declarations, no logic; imported by the sequencer and its opcode decoder.
package simplerisc_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_LSL  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_NOP  = 5'd13;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;
  localparam logic [4:0] OP_HALT = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXEC      = 3'd3,
    ST_EXEC_WAIT = 3'd4,
    ST_MEM       = 3'd5,
    ST_WB        = 3'd6,
    ST_STOP      = 3'd7
  } state_t;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_RA     = 2'd2;

endpackage

// File: rtl/simplerisc_op_decode.sv
// Combinational opcode-to-class decode for the sequencer; zero latency, no handshake.
module simplerisc_op_decode
  import simplerisc_pkg::*;
(
  input  logic [4:0] op,
  output logic       writes_rf,
  output logic       is_mem,
  output logic       is_multi,
  output logic       is_branch,
  output logic       is_illegal
);

  always_comb begin
    writes_rf  = op inside {[OP_ADD:OP_MOD], [OP_AND:OP_ASR], OP_LD};
    is_mem     = op inside {OP_LD, OP_ST};
    is_multi   = op inside {OP_MUL, OP_DIV, OP_MOD};
    is_branch  = op inside {[OP_BEQ:OP_RET]};
    is_illegal = op inside {[5'd21:5'd30]};
  end

endmodule

// File: rtl/simplerisc_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; Moore outputs, stalls on alu_done and dmem_ready.
// Optional SEQ_PERF_CNT_EN adds cycle_cnt/retired_cnt performance counters.
module simplerisc_seq_ctrl
  import simplerisc_pkg::*;
#(
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] inst,
  input  logic        flag_eq,
  input  logic        flag_gt,
  input  logic        alu_done,
  input  logic        dmem_ready,
  output logic        ir_load,
  output logic        alu_start,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        rd_ra,
  output logic        flags_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [31:0] is_branch_taken,
  output logic [2:0]  state_o,
  output logic        halted,
  output logic        trap
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retired_cnt
`endif
);

  localparam int TO_W = $clog2(DIV_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DIV_TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [4:0]      op_q;
  logic [4:0]      dec_op;
  logic [TO_W-1:0] to_cnt;
  logic            halted_q, trap_q;
  logic            set_halt, set_trap;
  logic            writes_rf, is_mem, is_multi, is_branch, is_illegal;
  logic            is_skip;
  logic            unused_inst;

  assign unused_inst = ^inst[26:0];

  // In DECODE the opcode is still on the instruction bus; afterwards only the latched copy is valid.
  assign dec_op = (state == ST_DECODE) ? inst[31:27] : op_q;

  simplerisc_op_decode u_dec (
    .op         (dec_op),
    .writes_rf  (writes_rf),
    .is_mem     (is_mem),
    .is_multi   (is_multi),
    .is_branch  (is_branch),
    .is_illegal (is_illegal)
  );

  assign is_skip = (dec_op == OP_NOP) ||
                   (is_branch && (dec_op != OP_BEQ) && (dec_op != OP_BGT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_ADD;
      halted_q <= 1'b0;
      trap_q   <= 1'b0;
      to_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) op_q <= inst[31:27];
      if (set_halt) halted_q <= 1'b1;
      if (set_trap) trap_q <= 1'b1;
      if ((state == ST_EXEC_WAIT) && (state_nxt == ST_EXEC_WAIT))
        to_cnt <= to_cnt + TO_W'(1);
      else
        to_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    alu_start = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    rd_ra     = 1'b0;
    flags_we  = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    set_halt  = 1'b0;
    set_trap  = 1'b0;
    case (state)
      ST_IDLE: if (run) state_nxt = ST_FETCH;
      ST_FETCH: begin
        ir_load   = 1'b1;
        state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_op == OP_HALT) begin
          set_halt  = 1'b1;
          state_nxt = ST_STOP;
        end else if (is_illegal) begin
          set_trap  = 1'b1;
          state_nxt = ST_STOP;
        end else if (is_skip) begin
          state_nxt = ST_WB;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_multi) begin
          alu_start = 1'b1;
          state_nxt = ST_EXEC_WAIT;
        end else if (is_mem) begin
          state_nxt = ST_MEM;
        end else begin
          state_nxt = ST_WB;
        end
      end
      ST_EXEC_WAIT: begin
        if (alu_done) begin
          state_nxt = ST_WB;
        end else if (to_cnt == TO_LAST) begin
          set_trap  = 1'b1;
          state_nxt = ST_STOP;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_ST);
        if (dmem_ready) state_nxt = ST_WB;
      end
      ST_WB: begin
        pc_we = 1'b1;
        rf_we = writes_rf || (op_q == OP_CALL);
        if (op_q == OP_LD) wb_sel = WB_MEM;
        if (op_q == OP_CALL) begin
          wb_sel = WB_PC4;
          rd_ra  = 1'b1;
        end
        flags_we = (op_q == OP_CMP);
        case (op_q)
          OP_B, OP_CALL: pc_sel = PC_BRANCH;
          OP_BEQ:        pc_sel = flag_eq ? PC_BRANCH : PC_PLUS4;
          OP_BGT:        pc_sel = flag_gt ? PC_BRANCH : PC_PLUS4;
          OP_RET:        pc_sel = PC_RA;
          default:       pc_sel = PC_PLUS4;
        endcase
        state_nxt = run ? ST_FETCH : ST_IDLE;
      end
      ST_STOP: state_nxt = ST_STOP;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign is_branch_taken = {31'b0, pc_sel != PC_PLUS4};
  assign state_o         = state;
  assign halted          = halted_q;
  assign trap            = trap_q;

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if ((state != ST_IDLE) && (state != ST_STOP)) cycle_cnt <= cycle_cnt + 32'd1;
      if (state == ST_WB) retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_simplerisc_seq_ctrl.sv
// Randomized bench: each instruction is expanded into a per-cycle expectation schedule from the CPI/output rules.
module tb_simplerisc_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [31:0] inst = '0;
  logic        flag_eq = 1'b0, flag_gt = 1'b0, alu_done = 1'b0, dmem_ready = 1'b0;
  logic        ir_load, alu_start, dmem_req, dmem_we, rf_we, rd_ra, flags_we, pc_we;
  logic [1:0]  wb_sel, pc_sel;
  logic [31:0] is_branch_taken;
  logic [2:0]  state_o;
  logic        halted, trap;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  simplerisc_seq_ctrl dut (
    .clk(clk), .reset(reset), .run(run), .inst(inst),
    .flag_eq(flag_eq), .flag_gt(flag_gt), .alu_done(alu_done), .dmem_ready(dmem_ready),
    .ir_load(ir_load), .alu_start(alu_start), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_we(rf_we), .wb_sel(wb_sel), .rd_ra(rd_ra), .flags_we(flags_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .is_branch_taken(is_branch_taken), .state_o(state_o),
    .halted(halted), .trap(trap)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic        ir_load, alu_start, dmem_req, dmem_we, rf_we, rd_ra, flags_we, pc_we, halted, trap;
    logic [1:0]  wb_sel, pc_sel;
    logic        run, alu_done, dmem_ready, flag_eq, flag_gt;
    logic [31:0] inst;
  } cyc_t;

  cyc_t q[$];
  cyc_t exp_c;
  bit   exp_vld = 0;
  int   checks = 0, errors = 0;
  bit   m_halted = 0, m_trap = 0;
  int   m_cyc = 0, m_ret = 0;
  int   obs_cyc = 0, obs_req = 0, obs_start = 0;
  logic [1:0]  last_pcsel = '0, last_wbsel = '0;
  logic        last_rfwe = 0;
  logic [31:0] last_ibt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic cyc_t mk(input logic [2:0] st);
    cyc_t c;
    c.st = st;
    c.ir_load = 0; c.alu_start = 0; c.dmem_req = 0; c.dmem_we = 0; c.rf_we = 0;
    c.rd_ra = 0; c.flags_we = 0; c.pc_we = 0; c.wb_sel = 0; c.pc_sel = 0;
    c.halted = m_halted; c.trap = m_trap;
    c.run = 1'($urandom); c.alu_done = 1'($urandom); c.dmem_ready = 1'($urandom);
    c.flag_eq = 1'($urandom); c.flag_gt = 1'($urandom); c.inst = $urandom;
    return c;
  endfunction

  task automatic push_idle(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin c = mk(3'd0); c.run = 0; q.push_back(c); end
    c = mk(3'd0); c.run = 1; q.push_back(c);
  endtask

  task automatic push_stop(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin c = mk(3'd7); c.run = 1; q.push_back(c); end
  endtask

  // One instruction from FETCH to WB (or to STOP), built straight from the stage/CPI rules.
  task automatic push_instr(input int op, input int w, input int m, input bit run_after,
                            input bit feq, input bit fgt);
    cyc_t c;
    logic [4:0] op5;
    op5 = op[4:0];
    c = mk(3'd1); c.ir_load = 1; c.inst[31:27] = op5; q.push_back(c);
    c = mk(3'd2); c.inst[31:27] = op5; q.push_back(c);
    if (op == 31) begin m_halted = 1; push_stop(3); return; end
    if (op >= 21 && op <= 30) begin m_trap = 1; push_stop(3); return; end
    if (!(op == 13 || op == 18 || op == 19 || op == 20)) begin
      c = mk(3'd3); c.alu_start = (op >= 2 && op <= 4); q.push_back(c);
      if (op >= 2 && op <= 4) begin
        for (int i = 1; i <= 64 && i <= w; i++) begin
          c = mk(3'd4); c.alu_done = (i == w); q.push_back(c);
        end
        if (w > 64) begin m_trap = 1; push_stop(3); return; end
      end
      if (op == 14 || op == 15) begin
        for (int i = 1; i <= m; i++) begin
          c = mk(3'd5); c.dmem_req = 1; c.dmem_we = (op == 15); c.dmem_ready = (i == m);
          q.push_back(c);
        end
      end
    end
    c = mk(3'd6);
    c.pc_we = 1;
    c.rf_we = (op <= 4) || (op >= 6 && op <= 12) || op == 14 || op == 19;
    c.wb_sel = (op == 14) ? 2'd1 : (op == 19) ? 2'd2 : 2'd0;
    c.rd_ra = (op == 19);
    c.flags_we = (op == 5);
    c.flag_eq = feq; c.flag_gt = fgt;
    if (op == 18 || op == 19 || (op == 16 && feq) || (op == 17 && fgt)) c.pc_sel = 2'd1;
    else if (op == 20) c.pc_sel = 2'd2;
    c.run = run_after;
    q.push_back(c);
  endtask

  task automatic play_n(input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      @(negedge clk);
      run = c.run; inst = c.inst; alu_done = c.alu_done; dmem_ready = c.dmem_ready;
      flag_eq = c.flag_eq; flag_gt = c.flag_gt;
      exp_c = c; exp_vld = 1;
    end
  endtask

  task automatic play();
    play_n(q.size());
    @(negedge clk);
    run = 0; alu_done = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; run = 0;
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_enables", 32'({ir_load, alu_start, dmem_req, dmem_we, rf_we, rd_ra, flags_we, pc_we}), 32'd0);
    chk("rst_sel", 32'({wb_sel, pc_sel}), 32'd0);
    chk("rst_taken", is_branch_taken, 32'd0);
    chk("rst_status", 32'({halted, trap}), 32'd0);
`ifdef SEQ_PERF_CNT_EN
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("rst_retired_cnt", retired_cnt, 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 0;
    m_halted = 0; m_trap = 0; m_cyc = 0; m_ret = 0;
    q.delete();
  endtask

  // Compare process: every scheduled cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (exp_vld) begin
        chk("state_o", 32'(state_o), 32'(exp_c.st));
        chk("ir_load", 32'(ir_load), 32'(exp_c.ir_load));
        chk("alu_start", 32'(alu_start), 32'(exp_c.alu_start));
        chk("dmem_req", 32'(dmem_req), 32'(exp_c.dmem_req));
        chk("dmem_we", 32'(dmem_we), 32'(exp_c.dmem_we));
        chk("rf_we", 32'(rf_we), 32'(exp_c.rf_we));
        chk("wb_sel", 32'(wb_sel), 32'(exp_c.wb_sel));
        chk("rd_ra", 32'(rd_ra), 32'(exp_c.rd_ra));
        chk("flags_we", 32'(flags_we), 32'(exp_c.flags_we));
        chk("pc_we", 32'(pc_we), 32'(exp_c.pc_we));
        chk("pc_sel", 32'(pc_sel), 32'(exp_c.pc_sel));
        chk("is_branch_taken", is_branch_taken, 32'(exp_c.pc_sel != 2'd0));
        chk("halted", 32'(halted), 32'(exp_c.halted));
        chk("trap", 32'(trap), 32'(exp_c.trap));
`ifdef SEQ_PERF_CNT_EN
        chk("cycle_cnt", cycle_cnt, 32'(m_cyc));
        chk("retired_cnt", retired_cnt, 32'(m_ret));
        if (exp_c.st != 3'd0 && exp_c.st != 3'd7) m_cyc++;
        if (exp_c.st == 3'd6) m_ret++;
`endif
        if (state_o == 3'd1) begin
          obs_cyc = 1; obs_req = 0; obs_start = 0;
        end else if (state_o >= 3'd2 && state_o <= 3'd6) begin
          obs_cyc++;
        end
        obs_req += int'(dmem_req);
        obs_start += int'(alu_start);
        if (state_o == 3'd6) begin
          last_pcsel = pc_sel; last_wbsel = wb_sel; last_rfwe = rf_we; last_ibt = is_branch_taken;
        end
        exp_vld = 0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int op, w, m, r;
    bit run_after, idle;
    int irl;
    do_reset();

    // add: FETCH, DECODE, EXEC, WB
    push_idle(1); push_instr(0, 0, 0, 0, 0, 0); push_idle(2); q.pop_back(); play();
    chk("add_cycles", 32'(obs_cyc), 32'd4);
    chk("add_rf_we", 32'(last_rfwe), 32'd1);
    chk("add_pc_sel", 32'(last_pcsel), 32'd0);

    // mul with alu_done on the third wait cycle
    push_idle(0); push_instr(2, 3, 0, 0, 0, 0); play();
    chk("mul_cycles", 32'(obs_cyc), 32'd7);
    chk("mul_start_pulses", 32'(obs_start), 32'd1);

    // ld with ready on the third MEM cycle
    push_idle(0); push_instr(14, 0, 3, 0, 0, 0); play();
    chk("ld_req_cycles", 32'(obs_req), 32'd3);
    chk("ld_wb_sel", 32'(last_wbsel), 32'd1);
    chk("ld_rf_we", 32'(last_rfwe), 32'd1);

    // cmp then beq, taken and not taken
    push_idle(0); push_instr(5, 0, 0, 1, 1, 0); push_instr(16, 0, 0, 0, 1, 0); play();
    chk("beq_taken_sel", 32'(last_pcsel), 32'd1);
    chk("beq_taken_vec", last_ibt, 32'h1);
    push_idle(0); push_instr(16, 0, 0, 0, 0, 1); play();
    chk("beq_not_taken_sel", 32'(last_pcsel), 32'd0);
    chk("beq_not_taken_vec", last_ibt, 32'h0);

    // illegal opcode 22
    push_idle(0); push_instr(22, 0, 0, 0, 0, 0); play();
    chk("illegal_trap", 32'(trap), 32'd1);
    chk("illegal_state", 32'(state_o), 32'd7);
    do_reset();

    // halt: no further fetch even with run held
    push_idle(0); push_instr(31, 0, 0, 0, 0, 0); play();
    run = 1; irl = 0;
    repeat (6) begin @(negedge clk); #1; irl += int'(ir_load); end
    run = 0;
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_no_fetch", 32'(irl), 32'd0);
    do_reset();

    // reset asserted while waiting in MEM
    push_idle(0); push_instr(14, 0, 5, 0, 0, 0); play_n(5);
    do_reset();
    chk("mem_abort_req", 32'(dmem_req), 32'd0);

    // divide that never completes
    push_idle(0); push_instr(3, 70, 0, 0, 0, 0); play();
    chk("div_timeout_trap", 32'(trap), 32'd1);
    do_reset();

    // randomized instruction stream
    idle = 1;
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) op = 31;
      else if (r < 6) op = $urandom_range(21, 30);
      else op = $urandom_range(0, 20);
      w = (r >= 6 && r < 8) ? $urandom_range(65, 67) : $urandom_range(1, 6);
      m = $urandom_range(1, 4);
      run_after = ($urandom_range(0, 3) != 0);
      if (idle) push_idle($urandom_range(0, 2));
      push_instr(op, w, m, run_after, 1'($urandom), 1'($urandom));
      play_n(q.size());
      if (m_halted || m_trap) begin
        play();
        do_reset();
        idle = 1;
      end else begin
        idle = !run_after;
      end
    end
    play();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simplerisc_seq_ctrl.md
# simplerisc_seq_ctrl

Multi-cycle control sequencer for the SimpleRISC core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the load enables and selects for the PC, instruction register, register file, flags and data memory. It also waits on the variable-latency mul/div/mod unit and on the data memory handshake. It sits beside the fetch/immediate datapath, and its branch-taken output feeds the fetch next-PC mux.

## Interface
- DIV_TIMEOUT, 64: maximum cycles in EXEC_WAIT before the trap.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- run  in  1  start/continue execution; sampled in IDLE and at the end of WB
- inst  in  32  instruction word from instruction memory (opcode = inst[31:27])
- flag_eq, flag_gt  in  1 each  registered comparison flags
- alu_done  in  1  multi-cycle ALU result valid (one-cycle pulse)
- dmem_ready  in  1  data memory accepted/completed request
- ir_load  out  1  load instruction register
- alu_start  out  1  one-cycle start pulse for mul/div/mod
- dmem_req, dmem_we  out  1 each  data memory request and write qualifier
- rf_we  out  1  register file write
- wb_sel  out  2  0 ALU, 1 memory data, 2 PC+4
- rd_ra  out  1  force destination to ra (r15)
- flags_we  out  1  update flags (cmp)
- pc_we  out  1  PC update
- pc_sel  out  2  0 PC+4, 1 branch target, 2 ra
- is_branch_taken  out  32  bit 0 = taken, bits 31:1 = 0
- state_o  out  3  current state encoding
- halted, trap  out  1 each  sticky status

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, EXEC_WAIT=4, MEM=5, WB=6, STOP=7.
- IDLE -> FETCH when run=1.
- FETCH: ir_load=1 -> DECODE.
- DECODE: opcode is latched internally.
  - nop(13), b(18), call(19), ret(20) -> WB.
  - beq(16), bgt(17) -> EXEC.
  - halt (31): halted=1 -> STOP.
  - 21..30: trap=1 -> STOP.
  - All others -> EXEC.
- EXEC: mul(2), div(3), mod(4) assert alu_start=1 -> EXEC_WAIT. ld(14) and st(15) -> MEM. All others -> WB.
- EXEC_WAIT: hold until alu_done -> WB. If DIV_TIMEOUT cycles pass without alu_done: trap=1 -> STOP.
- MEM: dmem_req=1 (dmem_we=1 for st) is held until a cycle with dmem_ready=1, then -> WB. A ready arriving in the first cycle means MEM lasts one cycle.
- WB:
  - pc_we=1.
  - rf_we=1 for opcodes 0-4, 6-12 and 14, with wb_sel=1 for ld and 0 otherwise.
  - call: rf_we=1, rd_ra=1, wb_sel=2.
  - cmp: flags_we=1, rf_we=0.
  - pc_sel: 1 for b, for call, for beq with flag_eq=1, and for bgt with flag_gt=1; 2 for ret; otherwise 0.
  - is_branch_taken[0] = (pc_sel != 0).
  - Next state: FETCH if run=1, else IDLE.
- STOP: all enables 0; leave only on reset.
- Outputs are decoded from registered state plus latched opcode (Moore). No enable is active in IDLE or STOP.

## Timing
- Reset: state IDLE; all outputs 0; halted=trap=0; opcode register 0; timeout counter 0.
- Reset asserted mid-instruction aborts immediately. No write enable is emitted after reset asserts.
- Cycles per instruction, with run held:
  - nop, b, call, ret: 3.
  - Simple ALU, cmp, branch-conditional: 4.
  - ld/st: 4 + MEM cycles.
  - mul/div/mod: 4 + wait cycles.
- alu_start is exactly one cycle per multi-cycle op.
- dmem_req never drops before dmem_ready is seen.
- Flags are sampled in WB, so a cmp followed by beq observes the updated flags.

## Configuration
- SEQ_PERF_CNT_EN defined: adds a 32-bit cycle_cnt output and a 32-bit retired_cnt output.
  - cycle_cnt counts every cycle outside IDLE and STOP.
  - retired_cnt increments on each WB cycle.
  - Both reset to 0 and wrap modulo 2^32.
- SEQ_PERF_CNT_EN undefined: neither port nor the counter logic exists.

## Structure
- Shared package simplerisc_pkg holds the opcode localparams (OP_ADD=0 .. OP_RET=20, OP_HALT=31), the state enum, and the wb_sel and pc_sel encodings.
- One sub-module, simplerisc_op_decode: combinational opcode-to-class decode (writes_rf, is_mem, is_multi, is_branch, is_illegal).

## Test plan
- add r1,r2,r3 with run=1: state_o sequence 1,2,3,6. rf_we=1 and pc_we=1 in the WB cycle only; pc_sel=0.
- mul with alu_done on the 3rd EXEC_WAIT cycle: alu_start is a single pulse; WB follows in the next cycle; total 7 cycles.
- ld with dmem_ready low for 2 cycles, then high: dmem_req high for 3 cycles; WB has wb_sel=1 and rf_we=1.
- cmp setting flag_eq=1, then beq: beq WB gives pc_sel=1 and is_branch_taken=32'h1. With flag_eq=0: pc_sel=0 and is_branch_taken=0.
- Opcode 22: trap=1 and state 7 after DECODE. Opcode 31: halted=1 and no further ir_load.
- Reset asserted during MEM: next cycle state_o=0 and dmem_req=0. With SEQ_PERF_CNT_EN, cycle_cnt and retired_cnt are 0.
